video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Raster timing generator for the HDMI output path, clocked by the 51 MHz pixel clock from the PLL. Holds the raster idle until the PLL reports lock and a settle interval has elapsed, then produces 1024x768@50 Hz timing. Outputs are hsync, vsync, data-enable, pixel coordinates and frame/line strobes, consumed by the framebuffer reader and the TMDS encoder. PLL lock loss drops the raster back to idle.

## Interface
Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch
- H_SYNC, 136, hsync width
- H_BP, 80, horizontal back porch (H total 1264)
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch
- V_SYNC, 6, vsync width
- V_BP, 31, vertical back porch (V total 808)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- LOCK_SETTLE, 1024, pixel cycles to wait after synchronized lock before running (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk_pixel  in  1  pixel clock (51 MHz)
- rst_pixel  in  1  synchronous active-high reset
- pll_locked  in  1  PLL lock, asynchronous to clk_pixel
- running  out  1  high while in RUN
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- de  out  1  active-video enable
- x  out  11  pixel column; valid when de
- y  out  10  pixel row; valid when de
- line_start  out  1  one-cycle pulse at h = 0 of every line
- frame_start  out  1  one-cycle pulse at h = 0, v = 0

## Operation
- pll_locked passes through a 2-FF synchronizer (lock_s). No other asynchronous input.
- FSM states:
  - WAIT_LOCK: go to SETTLE when lock_s = 1; clear settle counter.
  - SETTLE: count up. When the counter reaches LOCK_SETTLE-1, go to RUN with h = v = 0. lock_s = 0 returns to WAIT_LOCK.
  - RUN: h counts 0..H_TOTAL-1 and wraps. v increments on h wrap, 0..V_TOTAL-1, and wraps. lock_s = 0 returns to WAIT_LOCK on the next edge.
- Decode from (h, v), RUN only:
  - de = h < H_ACTIVE && v < V_ACTIVE
  - hsync active when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, i.e. [1048, 1184)
  - vsync active when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, i.e. [771, 777); vsync changes at h = 0 only
  - x = h, y = v when de; otherwise x and y hold 0
- Idle outputs (reset, WAIT_LOCK, SETTLE): hsync = ~HS_POL, vsync = ~VS_POL; de, x, y, strobes and running all 0.
- Widths: H_TOTAL and V_TOTAL are computed as 32-bit localparams. Counters are sized by $clog2 of the total. Compare unsigned, with no truncation.

## Timing
- All outputs are registered. They show the decode of the (h, v) value held in the previous cycle.
- Reset: on any edge with rst_pixel = 1, the FSM goes to WAIT_LOCK, both sync flops and all counters clear, and outputs take their idle values on that edge. Reset mid-frame drops the raster immediately.
- Lock latency: pll_locked rises before edge 0 → lock_s = 1 after edge 1 → SETTLE after edge 2 → RUN after edge 2+LOCK_SETTLE.
- First output: running = 1, de = 1, x = 0, y = 0, frame_start = 1, line_start = 1, all on the edge after RUN is entered.
- Lock loss: any lock_s = 0 in RUN or SETTLE reaches WAIT_LOCK, and outputs go idle, within 3 edges of pll_locked falling. A partial frame is abandoned.
- Relock after loss always restarts at h = v = 0 after a full LOCK_SETTLE.
- Glitch filtering: a 1-cycle lock glitch shorter than the synchronizer window may be missed. Any lock_s low sample restarts settling.

## Structure
- Package vid_timing_pkg: 1024x768@50 Hz default constants, H_TOTAL/V_TOTAL helper functions, FSM state enum (WAIT_LOCK, SETTLE, RUN).
- Sub-module sync_2ff (1-bit, parameterless) for the lock synchronizer. It is reused by other pixel-domain blocks.
- The rest, including FSM, counters and registered decode, is flat in video_timing_gen.

## Test plan
- Lock startup (LOCK_SETTLE = 4): rst_pixel for 3 cycles, raise pll_locked → first de = 1, x = 0, y = 0, frame_start = 1 exactly 7 edges after the rise.
- Full frame: run 1264×808 cycles →
  - de count = 786432
  - hsync active 136 cycles per line, first active at h = 1048
  - vsync active on lines 771–776
  - exactly one frame_start per 1021312 cycles
  - 808 line_start pulses per frame
- Wrap: check the cycle after h = 1263, v = 807 → h = 0, v = 0, frame_start = 1. After h = 1263, v = 10 → line_start = 1, y = 11 at the next de.
- Lock loss mid-line (h = 500, v = 300): drop pll_locked → within 3 edges de = 0, hsync = 1, vsync = 1, running = 0. Relock → restart at (0, 0) after settle.
- Reset mid-frame: assert rst_pixel at v = 400 → idle outputs on the same edge. With pll_locked held high, RUN resumes 3+LOCK_SETTLE edges after rst_pixel drops.
- Polarity: HS_POL = 1, VS_POL = 1 → syncs idle low, active high, with identical windows to the default case.

Source files
------------

// File: rtl/vid_timing_pkg.sv
// Shared constants, raster-total helpers and FSM state encoding for the
// pixel-domain video timing logic (1024x768@50 Hz on a 51 MHz pixel clock).
package vid_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE    = 1024;
  localparam int unsigned DEF_H_FP        = 24;
  localparam int unsigned DEF_H_SYNC      = 136;
  localparam int unsigned DEF_H_BP        = 80;
  localparam int unsigned DEF_V_ACTIVE    = 768;
  localparam int unsigned DEF_V_FP        = 3;
  localparam int unsigned DEF_V_SYNC      = 6;
  localparam int unsigned DEF_V_BP        = 31;
  localparam int unsigned DEF_LOCK_SETTLE = 1024;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } vt_state_e;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit level crossing into the pixel domain.
// Synchronous active-high reset clears both stages.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: waits for PLL lock plus a settle interval, then
// scans (h, v) and emits registered sync/enable/coordinate/strobe outputs.
//
// state     | meaning
// WAIT_LOCK | raster idle, waiting for synchronized lock
// SETTLE    | lock seen, counting LOCK_SETTLE cycles before running
// RUN       | raster scanning, outputs decoded from (h, v)
module video_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BP        = DEF_H_BP,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BP        = DEF_V_BP,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int unsigned LOCK_SETTLE = DEF_LOCK_SETTLE
) (
  input  logic        clk_pixel,
  input  logic        rst_pixel,
  input  logic        pll_locked,
  output logic        running,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned SW      = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk (clk_pixel),
    .rst (rst_pixel),
    .d   (pll_locked),
    .q   (lock_s)
  );

  vt_state_e       state_q, state_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic            running_q, running_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            de_q, de_d;
  logic [10:0]     x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic            line_start_q, line_start_d;
  logic            frame_start_q, frame_start_d;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      WAIT_LOCK: begin
        settle_d = '0;
        if (lock_s) state_d = SETTLE;
      end
      SETTLE: begin
        if (!lock_s) begin
          state_d  = WAIT_LOCK;
          settle_d = '0;
        end else if (32'(settle_q) == LOCK_SETTLE - 1) begin
          state_d  = RUN;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) state_d = WAIT_LOCK;
      end
      default: begin
        state_d  = WAIT_LOCK;
        settle_d = '0;
      end
    endcase
  end

  // Decode only while RUN persists across this edge, so entry shows (0,0)
  // one edge later and lock loss idles the outputs on the same edge.
  logic run_go;
  logic h_last, v_last;
  logic h_act, v_act, hs_on, vs_on;

  always_comb begin
    run_go = (state_q == RUN) && lock_s;
    h_last = (32'(h_q) == H_TOTAL - 1);
    v_last = (32'(v_q) == V_TOTAL - 1);
    h_act  = (32'(h_q) < H_ACTIVE);
    v_act  = (32'(v_q) < V_ACTIVE);
    hs_on  = (32'(h_q) >= H_ACTIVE + H_FP) && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
    vs_on  = (32'(v_q) >= V_ACTIVE + V_FP) && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);

    h_d = '0;
    v_d = '0;
    if (run_go) begin
      h_d = h_last ? '0 : h_q + 1'b1;
      v_d = v_q;
      if (h_last) v_d = v_last ? '0 : v_q + 1'b1;
    end

    running_d     = 1'b0;
    hsync_d       = ~HS_POL;
    vsync_d       = ~VS_POL;
    de_d          = 1'b0;
    x_d           = '0;
    y_d           = '0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (run_go) begin
      running_d     = 1'b1;
      de_d          = h_act && v_act;
      hsync_d       = hs_on ? HS_POL : ~HS_POL;
      vsync_d       = vs_on ? VS_POL : ~VS_POL;
      x_d           = de_d ? 11'(h_q) : '0;
      y_d           = de_d ? 10'(v_q) : '0;
      line_start_d  = (h_q == '0);
      frame_start_d = (h_q == '0) && (v_q == '0);
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (rst_pixel) begin
      state_q       <= WAIT_LOCK;
      settle_q      <= '0;
      h_q           <= '0;
      v_q           <= '0;
      running_q     <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      h_q           <= h_d;
      v_q           <= v_d;
      running_q     <= running_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign running     = running_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: full-size raster for lock/line/lock-loss behaviour, plus a
// reduced 25x14 raster (both sync polarities) for whole-frame behaviour.
module tb_video_timing_gen;

  logic clk;
  logic rst_a, lock_a, rst_b, lock_b;

  logic        a_running, a_hsync, a_vsync, a_de, a_ls, a_fs;
  logic [10:0] a_x;
  logic [9:0]  a_y;
  logic        s_running, s_hsync, s_vsync, s_de, s_ls, s_fs;
  logic [10:0] s_x;
  logic [9:0]  s_y;
  logic        p_running, p_hsync, p_vsync, p_de, p_ls, p_fs;
  logic [10:0] p_x;
  logic [9:0]  p_y;

  int checks = 0;
  int errors = 0;

  video_timing_gen #(.LOCK_SETTLE(4)) dut_a (
    .clk_pixel(clk), .rst_pixel(rst_a), .pll_locked(lock_a),
    .running(a_running), .hsync(a_hsync), .vsync(a_vsync), .de(a_de),
    .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs)
  );

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_SETTLE(4)
  ) dut_s (
    .clk_pixel(clk), .rst_pixel(rst_b), .pll_locked(lock_b),
    .running(s_running), .hsync(s_hsync), .vsync(s_vsync), .de(s_de),
    .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
  );

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_SETTLE(4)
  ) dut_p (
    .clk_pixel(clk), .rst_pixel(rst_b), .pll_locked(lock_b),
    .running(p_running), .hsync(p_hsync), .vsync(p_vsync), .de(p_de),
    .x(p_x), .y(p_y), .line_start(p_ls), .frame_start(p_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; lock_a = 1'b0; rst_b = 1'b1; lock_b = 1'b0;
    repeat (3) tick();
    checks++; if (a_running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b want 0", a_running); end
    checks++; if (a_de !== 1'b0) begin errors++; $display("FAIL reset_de: got %0b want 0", a_de); end
    checks++; if (a_hsync !== 1'b1 || a_vsync !== 1'b1) begin errors++; $display("FAIL reset_syncs: got hs=%0b vs=%0b want 1 1", a_hsync, a_vsync); end
    checks++; if (a_x !== 11'd0 || a_y !== 10'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", a_x, a_y); end
    checks++; if (a_ls !== 1'b0 || a_fs !== 1'b0) begin errors++; $display("FAIL reset_strobes: got ls=%0b fs=%0b want 0 0", a_ls, a_fs); end
    checks++; if (p_hsync !== 1'b0 || p_vsync !== 1'b0) begin errors++; $display("FAIL reset_pol_syncs: got hs=%0b vs=%0b want 0 0", p_hsync, p_vsync); end
  endtask

  task automatic test_lock_startup();
    int early;
    early = 0;
    rst_a = 1'b0; lock_a = 1'b1;
    for (int e = 0; e < 7; e++) begin
      tick();
      if (a_running !== 1'b0 || a_de !== 1'b0 || a_fs !== 1'b0) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL startup_early: got %0d active edges want 0", early); end
    tick();
    checks++; if (a_running !== 1'b1) begin errors++; $display("FAIL startup_running: got %0b want 1", a_running); end
    checks++; if (a_de !== 1'b1 || a_x !== 11'd0 || a_y !== 10'd0) begin errors++; $display("FAIL startup_first_pixel: got de=%0b x=%0d y=%0d want 1 0 0", a_de, a_x, a_y); end
    checks++; if (a_fs !== 1'b1 || a_ls !== 1'b1) begin errors++; $display("FAIL startup_strobes: got fs=%0b ls=%0b want 1 1", a_fs, a_ls); end
  endtask

  task automatic test_first_line();
    int de_n, hs_n, hs_first, hs_last, ls_n, fs_n, vs_n, xbad;
    de_n = 0; hs_n = 0; hs_first = -1; hs_last = -1; ls_n = 0; fs_n = 0; vs_n = 0; xbad = 0;
    for (int h = 0; h < 1264; h++) begin
      if (a_de) begin
        de_n++;
        if (a_x !== 11'(h) || a_y !== 10'd0) xbad++;
      end else if (a_x !== 11'd0 || a_y !== 10'd0) xbad++;
      if (a_hsync === 1'b0) begin
        hs_n++;
        if (hs_first < 0) hs_first = h;
        hs_last = h;
      end
      if (a_vsync === 1'b0) vs_n++;
      if (a_ls) ls_n++;
      if (a_fs) fs_n++;
      tick();
    end
    checks++; if (de_n !== 1024) begin errors++; $display("FAIL line_de_count: got %0d want 1024", de_n); end
    checks++; if (hs_n !== 136) begin errors++; $display("FAIL line_hsync_count: got %0d want 136", hs_n); end
    checks++; if (hs_first !== 1048 || hs_last !== 1183) begin errors++; $display("FAIL line_hsync_window: got %0d..%0d want 1048..1183", hs_first, hs_last); end
    checks++; if (vs_n !== 0) begin errors++; $display("FAIL line_vsync_idle: got %0d active want 0", vs_n); end
    checks++; if (ls_n !== 1 || fs_n !== 1) begin errors++; $display("FAIL line_strobes: got ls=%0d fs=%0d want 1 1", ls_n, fs_n); end
    checks++; if (xbad !== 0) begin errors++; $display("FAIL line_xy: got %0d bad samples want 0", xbad); end
    checks++; if (a_ls !== 1'b1 || a_fs !== 1'b0 || a_de !== 1'b1 || a_y !== 10'd1 || a_x !== 11'd0) begin
      errors++; $display("FAIL line1_start: got ls=%0b fs=%0b de=%0b x=%0d y=%0d want 1 0 1 0 1", a_ls, a_fs, a_de, a_x, a_y);
    end
  endtask

  task automatic test_line_wrap();
    repeat (9 * 1264 + 1263) tick();
    checks++; if (a_de !== 1'b0 || a_x !== 11'd0 || a_y !== 10'd0 || a_ls !== 1'b0 || a_hsync !== 1'b1) begin
      errors++; $display("FAIL wrap_h1263_v10: got de=%0b x=%0d y=%0d ls=%0b hs=%0b want 0 0 0 0 1", a_de, a_x, a_y, a_ls, a_hsync);
    end
    tick();
    checks++; if (a_ls !== 1'b1 || a_de !== 1'b1 || a_y !== 10'd11 || a_x !== 11'd0) begin
      errors++; $display("FAIL wrap_line11: got ls=%0b de=%0b x=%0d y=%0d want 1 1 0 11", a_ls, a_de, a_x, a_y);
    end
  endtask

  task automatic test_lock_loss();
    int idle_at, early;
    repeat (500) tick();
    checks++; if (a_de !== 1'b1 || a_x !== 11'd500 || a_y !== 10'd11) begin
      errors++; $display("FAIL loss_position: got de=%0b x=%0d y=%0d want 1 500 11", a_de, a_x, a_y);
    end
    lock_a = 1'b0;
    idle_at = -1;
    for (int e = 0; e < 3; e++) begin
      tick();
      if (idle_at < 0 && a_de === 1'b0 && a_running === 1'b0 && a_hsync === 1'b1 && a_vsync === 1'b1) idle_at = e;
    end
    checks++; if (idle_at < 0) begin errors++; $display("FAIL loss_idle_within_3: got not idle after 3 edges want idle"); end
    repeat (5) tick();
    checks++; if (a_running !== 1'b0 || a_de !== 1'b0 || a_x !== 11'd0 || a_y !== 10'd0) begin
      errors++; $display("FAIL loss_hold_idle: got run=%0b de=%0b x=%0d y=%0d want 0 0 0 0", a_running, a_de, a_x, a_y);
    end
    lock_a = 1'b1;
    early = 0;
    for (int e = 0; e < 7; e++) begin
      tick();
      if (a_running !== 1'b0 || a_de !== 1'b0) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL relock_early: got %0d active edges want 0", early); end
    tick();
    checks++; if (a_running !== 1'b1 || a_fs !== 1'b1 || a_de !== 1'b1 || a_x !== 11'd0 || a_y !== 10'd0) begin
      errors++; $display("FAIL relock_origin: got run=%0b fs=%0b de=%0b x=%0d y=%0d want 1 1 1 0 0", a_running, a_fs, a_de, a_x, a_y);
    end
  endtask

  task automatic test_full_frame();
    int de_n, hs_n, vs_n, fs_n, ls_n, win_bad, pol_bad, pos_bad, xy_bad, phs_n;
    logic hs_win, vs_win, de_win;
    de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0; ls_n = 0; win_bad = 0; pol_bad = 0; pos_bad = 0; xy_bad = 0; phs_n = 0;
    rst_b = 1'b0; lock_b = 1'b1;
    repeat (8) tick();
    checks++; if (s_fs !== 1'b1 || p_fs !== 1'b1) begin errors++; $display("FAIL frame_first_fs: got %0b %0b want 1 1", s_fs, p_fs); end
    for (int f = 0; f < 2; f++) begin
      for (int v = 0; v < 14; v++) begin
        for (int h = 0; h < 25; h++) begin
          hs_win = (h >= 18) && (h < 21);
          vs_win = (v >= 9) && (v < 11);
          de_win = (h < 16) && (v < 8);
          if (s_de) de_n++;
          if (s_hsync === 1'b0) hs_n++;
          if (s_vsync === 1'b0) vs_n++;
          if (p_hsync === 1'b1) phs_n++;
          if (s_fs) fs_n++;
          if (s_ls) ls_n++;
          if ((s_hsync === 1'b0) !== hs_win || (s_vsync === 1'b0) !== vs_win || s_de !== de_win) win_bad++;
          if ((p_hsync === 1'b1) !== hs_win || (p_vsync === 1'b1) !== vs_win || p_de !== de_win) pol_bad++;
          if (s_fs !== (h == 0 && v == 0) || s_ls !== (h == 0)) pos_bad++;
          if (de_win ? (s_x !== 11'(h) || s_y !== 10'(v)) : (s_x !== 11'd0 || s_y !== 10'd0)) xy_bad++;
          tick();
        end
      end
    end
    checks++; if (de_n !== 256) begin errors++; $display("FAIL frame_de_count: got %0d want 256", de_n); end
    checks++; if (hs_n !== 84) begin errors++; $display("FAIL frame_hsync_count: got %0d want 84", hs_n); end
    checks++; if (vs_n !== 100) begin errors++; $display("FAIL frame_vsync_count: got %0d want 100", vs_n); end
    checks++; if (phs_n !== 84) begin errors++; $display("FAIL pol_hsync_count: got %0d want 84", phs_n); end
    checks++; if (fs_n !== 2) begin errors++; $display("FAIL frame_fs_count: got %0d want 2", fs_n); end
    checks++; if (ls_n !== 28) begin errors++; $display("FAIL frame_ls_count: got %0d want 28", ls_n); end
    checks++; if (win_bad !== 0) begin errors++; $display("FAIL frame_windows: got %0d bad samples want 0", win_bad); end
    checks++; if (pol_bad !== 0) begin errors++; $display("FAIL pol_windows: got %0d bad samples want 0", pol_bad); end
    checks++; if (pos_bad !== 0) begin errors++; $display("FAIL frame_strobe_pos: got %0d bad samples want 0", pos_bad); end
    checks++; if (xy_bad !== 0) begin errors++; $display("FAIL frame_xy: got %0d bad samples want 0", xy_bad); end
    checks++; if (s_fs !== 1'b1 || s_de !== 1'b1 || s_x !== 11'd0 || s_y !== 10'd0) begin
      errors++; $display("FAIL frame_wrap: got fs=%0b de=%0b x=%0d y=%0d want 1 1 0 0", s_fs, s_de, s_x, s_y);
    end
  endtask

  task automatic test_reset_mid_frame();
    int early;
    repeat (5 * 25 + 7) tick();
    checks++; if (s_de !== 1'b1 || s_x !== 11'd7 || s_y !== 10'd5) begin
      errors++; $display("FAIL rstmid_position: got de=%0b x=%0d y=%0d want 1 7 5", s_de, s_x, s_y);
    end
    rst_b = 1'b1;
    tick();
    checks++; if (s_de !== 1'b0 || s_running !== 1'b0 || s_hsync !== 1'b1 || s_vsync !== 1'b1 || s_x !== 11'd0 || s_y !== 10'd0) begin
      errors++; $display("FAIL rstmid_idle: got de=%0b run=%0b hs=%0b vs=%0b x=%0d y=%0d want 0 0 1 1 0 0", s_de, s_running, s_hsync, s_vsync, s_x, s_y);
    end
    checks++; if (p_hsync !== 1'b0 || p_vsync !== 1'b0) begin errors++; $display("FAIL rstmid_pol_idle: got hs=%0b vs=%0b want 0 0", p_hsync, p_vsync); end
    rst_b = 1'b0;
    early = 0;
    for (int e = 0; e < 7; e++) begin
      tick();
      if (s_running !== 1'b0) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL rstmid_early: got %0d running edges want 0", early); end
    tick();
    checks++; if (s_running !== 1'b1 || s_fs !== 1'b1 || s_x !== 11'd0 || s_y !== 10'd0) begin
      errors++; $display("FAIL rstmid_resume: got run=%0b fs=%0b x=%0d y=%0d want 1 1 0 0", s_running, s_fs, s_x, s_y);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lock_startup();
    test_first_line();
    test_line_wrap();
    test_lock_loss();
    test_full_frame();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
